bp_be_fma_wb_scheduler: RTL and testbench

- Issue-side scheduler for the shared FMA/IMUL pipe. The pipe produces IMUL results after a fixed 3-cycle latency and FMA results after 4 cycles, and both leave through one writeback port.
- The block reserves writeback slots at issue so IMUL and FMA results never collide, and back-pressures the issuer when a collision would occur.
- It predicts each result's writeback cycle and destination tag, applies pipeline flushes to in-flight reservations, and exposes per-register busy status for the scoreboard.

---
 rtl/bp_be_fma_wb_scheduler.sv | 158 +++++++++++++++
 tb/tb_bp_be_fma_wb_scheduler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_fma_wb_scheduler.sv
// Writeback-slot scheduler for the shared FMA/IMUL pipe.
// Reserves a writeback slot when an op issues, so IMUL and FMA results never
// leave the pipe in the same cycle. Tracks in-flight destination tags for the
// scoreboard and squashes young reservations on flush.
// Optional statistics counters: define BP_BE_FMA_SCHED_STATS_EN.
module bp_be_fma_wb_scheduler #(
    parameter int unsigned fma_latency_p  = 4,
    parameter int unsigned imul_latency_p = 3,
    parameter int unsigned tag_width_p    = 5,
    parameter int unsigned flush_depth_p  = 2
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   issue_v_i,
    input  logic                   issue_fp_i,
    input  logic [tag_width_p-1:0] issue_tag_i,
    output logic                   issue_ready_o,
    input  logic                   flush_i,
    output logic                   wb_v_o,
    output logic                   wb_fp_o,
    output logic [tag_width_p-1:0] wb_tag_o,
    input  logic [tag_width_p-1:0] query_tag_i,
    input  logic                   query_fp_i,
    output logic                   query_busy_o,
    output logic [2:0]             inflight_cnt_o
`ifdef BP_BE_FMA_SCHED_STATS_EN
    ,
    output logic [31:0]            stall_cnt_o,
    output logic [15:0]            flush_kill_cnt_o
`endif
);

    // Index 0 is the slot writing back this cycle; the youngest FMA lands at Depth-1.
    localparam int unsigned Depth   = fma_latency_p - 1;
    localparam int unsigned FmaIdx  = fma_latency_p - 2;
    localparam int unsigned ImulIdx = imul_latency_p - 2;

    logic [Depth-1:0]                  slot_v_q, slot_v_d;
    logic [Depth-1:0]                  slot_fp_q, slot_fp_d;
    logic [Depth-1:0][tag_width_p-1:0] slot_tag_q, slot_tag_d;
    logic [2:0]                        cnt_q, cnt_d;
    logic [7:0]                        pop;
    logic                              accept;
    logic                              busy;

`ifdef BP_BE_FMA_SCHED_STATS_EN
    logic [15:0] kill_num;
    logic [16:0] kill_sum;
`endif

    // An IMUL would land on the slot an FMA from last cycle is shifting into;
    // an FMA always lands on the freshly vacated top slot.
    assign issue_ready_o = issue_fp_i | ~slot_v_q[imul_latency_p-1];
    assign accept        = issue_v_i & issue_ready_o;

    assign wb_v_o   = slot_v_q[0];
    assign wb_fp_o  = slot_fp_q[0];
    assign wb_tag_o = slot_tag_q[0];

    // Shift the slot array, apply flush to young survivors, then insert the new issue.
    always_comb begin
        slot_v_d   = '0;
        slot_fp_d  = '0;
        slot_tag_d = '0;
`ifdef BP_BE_FMA_SCHED_STATS_EN
        kill_num   = '0;
`endif
        for (int k = 0; k < int'(Depth) - 1; k++) begin
            slot_v_d[k]   = slot_v_q[k+1];
            slot_fp_d[k]  = slot_fp_q[k+1];
            slot_tag_d[k] = slot_tag_q[k+1];
        end
        if (flush_i) begin
            for (int k = 0; k < int'(Depth) - 1; k++) begin
                // Age after the shift, measured against the entry's own latency.
                if (slot_v_d[k] &&
                    (((slot_fp_d[k] ? int'(FmaIdx) : int'(ImulIdx)) - k) < int'(flush_depth_p)))
                begin
                    slot_v_d[k] = 1'b0;
`ifdef BP_BE_FMA_SCHED_STATS_EN
                    kill_num = kill_num + 16'd1;
`endif
                end
            end
        end
        if (accept) begin
            if (flush_i && (flush_depth_p != 0)) begin
                // Same-cycle issue has age 0 and is always inside the flush window.
`ifdef BP_BE_FMA_SCHED_STATS_EN
                kill_num = kill_num + 16'd1;
`endif
            end else if (issue_fp_i) begin
                slot_v_d[FmaIdx]   = 1'b1;
                slot_fp_d[FmaIdx]  = 1'b1;
                slot_tag_d[FmaIdx] = issue_tag_i;
            end else begin
                slot_v_d[ImulIdx]   = 1'b1;
                slot_fp_d[ImulIdx]  = 1'b0;
                slot_tag_d[ImulIdx] = issue_tag_i;
            end
        end
    end

    // Population count of next-state valid bits, saturating at 7.
    always_comb begin
        pop = '0;
        for (int k = 0; k < int'(Depth); k++) begin
            pop = pop + 8'(slot_v_d[k]);
        end
        cnt_d = (pop > 8'd7) ? 3'd7 : pop[2:0];
    end

    // Scoreboard lookup over every valid slot, including the one writing back.
    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < int'(Depth); k++) begin
            if (slot_v_q[k] && (slot_fp_q[k] == query_fp_i) && (slot_tag_q[k] == query_tag_i)) begin
                busy = 1'b1;
            end
        end
    end

    assign query_busy_o   = busy;
    assign inflight_cnt_o = cnt_q;

    // Slot array and occupancy state.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            slot_v_q   <= '0;
            slot_fp_q  <= '0;
            slot_tag_q <= '0;
            cnt_q      <= '0;
        end else begin
            slot_v_q   <= slot_v_d;
            slot_fp_q  <= slot_fp_d;
            slot_tag_q <= slot_tag_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef BP_BE_FMA_SCHED_STATS_EN
    assign kill_sum = {1'b0, flush_kill_cnt_o} + {1'b0, kill_num};

    // Saturating stall and flush-kill statistics.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stall_cnt_o      <= '0;
            flush_kill_cnt_o <= '0;
        end else begin
            if (issue_v_i && !issue_ready_o && (stall_cnt_o != 32'hFFFF_FFFF)) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            flush_kill_cnt_o <= kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_bp_be_fma_wb_scheduler.sv
// Directed self-checking bench for bp_be_fma_wb_scheduler (default parameters).
module tb_bp_be_fma_wb_scheduler;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       issue_v;
    logic       issue_fp;
    logic [4:0] issue_tag;
    logic       issue_ready;
    logic       flush;
    logic       wb_v;
    logic       wb_fp;
    logic [4:0] wb_tag;
    logic [4:0] query_tag;
    logic       query_fp;
    logic       query_busy;
    logic [2:0] inflight_cnt;
`ifdef BP_BE_FMA_SCHED_STATS_EN
    logic [31:0] stall_cnt;
    logic [15:0] flush_kill_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    bp_be_fma_wb_scheduler dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .issue_v_i      (issue_v),
        .issue_fp_i     (issue_fp),
        .issue_tag_i    (issue_tag),
        .issue_ready_o  (issue_ready),
        .flush_i        (flush),
        .wb_v_o         (wb_v),
        .wb_fp_o        (wb_fp),
        .wb_tag_o       (wb_tag),
        .query_tag_i    (query_tag),
        .query_fp_i     (query_fp),
        .query_busy_o   (query_busy),
        .inflight_cnt_o (inflight_cnt)
`ifdef BP_BE_FMA_SCHED_STATS_EN
        ,
        .stall_cnt_o      (stall_cnt),
        .flush_kill_cnt_o (flush_kill_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge; outputs settle 1ns later.
    task automatic cyc(input logic v, input logic fp, input logic [4:0] tag, input logic fl);
        @(negedge clk);
        issue_v   = v;
        issue_fp  = fp;
        issue_tag = tag;
        flush     = fl;
        #1;
    endtask

    task automatic chk_wb(input string name, input logic v, input logic fp, input logic [4:0] tag);
        check({name, "_wb_v"}, 32'(wb_v), 32'(v));
        if (v) begin
            check({name, "_wb_fp"}, 32'(wb_fp), 32'(fp));
            check({name, "_wb_tag"}, 32'(wb_tag), 32'(tag));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b0, 5'd0, 1'b0);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        issue_v   = 1'b0;
        issue_fp  = 1'b0;
        issue_tag = '0;
        flush     = 1'b0;
        query_tag = '0;
        query_fp  = 1'b0;

        // Reset state
        @(negedge clk);
        #1;
        check("rst_wb_v", 32'(wb_v), 32'd0);
        check("rst_wb_fp", 32'(wb_fp), 32'd0);
        check("rst_wb_tag", 32'(wb_tag), 32'd0);
        check("rst_busy", 32'(query_busy), 32'd0);
        check("rst_cnt", 32'(inflight_cnt), 32'd0);
        check("rst_ready", 32'(issue_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);
        check("post_rst_wb_v", 32'(wb_v), 32'd0);
        check("post_rst_ready", 32'(issue_ready), 32'd1);

        // FMA tag 5: writeback 3 cycles later, busy for cycles +1..+3
        query_tag = 5'd5;
        query_fp  = 1'b1;
        cyc(1'b1, 1'b1, 5'd5, 1'b0);
        check("fma_ready", 32'(issue_ready), 32'd1);
        check("fma_busy0", 32'(query_busy), 32'd0);
        chk_wb("fma_c0", 1'b0, 1'b0, 5'd0);
        cyc(1'b0, 1'b0, 5'd0, 1'b0);
        chk_wb("fma_c1", 1'b0, 1'b0, 5'd0);
        check("fma_busy1", 32'(query_busy), 32'd1);
        check("fma_cnt1", 32'(inflight_cnt), 32'd1);
        cyc(1'b0, 1'b0, 5'd0, 1'b0);
        chk_wb("fma_c2", 1'b0, 1'b0, 5'd0);
        check("fma_busy2", 32'(query_busy), 32'd1);
        cyc(1'b0, 1'b0, 5'd0, 1'b0);
        chk_wb("fma_c3", 1'b1, 1'b1, 5'd5);
        check("fma_busy3", 32'(query_busy), 32'd1);
        query_fp = 1'b0;
        #1;
        check("fma_busy3_wrong_rf", 32'(query_busy), 32'd0);
        query_fp = 1'b1;
        cyc(1'b0, 1'b0, 5'd0, 1'b0);
        chk_wb("fma_c4", 1'b0, 1'b0, 5'd0);
        check("fma_busy4", 32'(query_busy), 32'd0);
        check("fma_cnt4", 32'(inflight_cnt), 32'd0);

        // IMUL tag 3: writeback 2 cycles later
        query_tag = 5'd3;
        query_fp  = 1'b0;
        cyc(1'b1, 1'b0, 5'd3, 1'b0);
        check("imul_ready", 32'(issue_ready), 32'd1);
        cyc(1'b0, 1'b0, 5'd0, 1'b0);
        chk_wb("imul_c1", 1'b0, 1'b0, 5'd0);
        check("imul_busy1", 32'(query_busy), 32'd1);
        cyc(1'b0, 1'b0, 5'd0, 1'b0);
        chk_wb("imul_c2", 1'b1, 1'b0, 5'd3);
        check("imul_busy2", 32'(query_busy), 32'd1);
        cyc(1'b0, 1'b0, 5'd0, 1'b0);
        chk_wb("imul_c3", 1'b0, 1'b0, 5'd0);
        check("imul_busy3", 32'(query_busy), 32'd0);

        // FMA then IMUL: IMUL stalled one cycle, writebacks serialised
        cyc(1'b1, 1'b1, 5'd7, 1'b0);
        cyc(1'b1, 1'b0, 5'd8, 1'b0);
        check("coll_imul_blocked", 32'(issue_ready), 32'd0);
        issue_fp = 1'b1;
        #1;
        check("coll_fma_ready", 32'(issue_ready), 32'd1);
        issue_fp = 1'b0;
        #1;
        chk_wb("coll_c1", 1'b0, 1'b0, 5'd0);
        cyc(1'b1, 1'b0, 5'd8, 1'b0);
        check("coll_imul_ready", 32'(issue_ready), 32'd1);
        chk_wb("coll_c2", 1'b0, 1'b0, 5'd0);
        cyc(1'b0, 1'b0, 5'd0, 1'b0);
        chk_wb("coll_c3", 1'b1, 1'b1, 5'd7);
        check("coll_cnt3", 32'(inflight_cnt), 32'd2);
        cyc(1'b0, 1'b0, 5'd0, 1'b0);
        chk_wb("coll_c4", 1'b1, 1'b0, 5'd8);
        cyc(1'b0, 1'b0, 5'd0, 1'b0);
        chk_wb("coll_c5", 1'b0, 1'b0, 5'd0);

        // IMUL then FMA with flush on the FMA cycle: both squashed
        query_tag = 5'd9;
        query_fp  = 1'b0;
        cyc(1'b1, 1'b0, 5'd9, 1'b0);
        cyc(1'b1, 1'b1, 5'd10, 1'b1);
        check("fl_fma_ready", 32'(issue_ready), 32'd1);
        cyc(1'b0, 1'b0, 5'd0, 1'b0);
        chk_wb("fl_c2", 1'b0, 1'b0, 5'd0);
        check("fl_cnt2", 32'(inflight_cnt), 32'd0);
        check("fl_busy2", 32'(query_busy), 32'd0);
        cyc(1'b0, 1'b0, 5'd0, 1'b0);
        chk_wb("fl_c3", 1'b0, 1'b0, 5'd0);
        cyc(1'b0, 1'b0, 5'd0, 1'b0);
        chk_wb("fl_c4", 1'b0, 1'b0, 5'd0);

        // FMA, flush two cycles later: age 2 survives
        query_tag = 5'd11;
        query_fp  = 1'b1;
        cyc(1'b1, 1'b1, 5'd11, 1'b0);
        cyc(1'b0, 1'b0, 5'd0, 1'b0);
        cyc(1'b0, 1'b0, 5'd0, 1'b1);
        check("old_busy2", 32'(query_busy), 32'd1);
        cyc(1'b0, 1'b0, 5'd0, 1'b0);
        chk_wb("old_c3", 1'b1, 1'b1, 5'd11);
        check("old_cnt3", 32'(inflight_cnt), 32'd1);
        cyc(1'b0, 1'b0, 5'd0, 1'b0);
        chk_wb("old_c4", 1'b0, 1'b0, 5'd0);

        // FMA, flush one cycle later: age 1 killed
        query_tag = 5'd12;
        cyc(1'b1, 1'b1, 5'd12, 1'b0);
        cyc(1'b0, 1'b0, 5'd0, 1'b1);
        check("young_busy1", 32'(query_busy), 32'd1);
        cyc(1'b0, 1'b0, 5'd0, 1'b0);
        check("young_busy2", 32'(query_busy), 32'd0);
        check("young_cnt2", 32'(inflight_cnt), 32'd0);
        cyc(1'b0, 1'b0, 5'd0, 1'b0);
        chk_wb("young_c3", 1'b0, 1'b0, 5'd0);

        // Three FMAs in flight, then asynchronous reset mid-cycle
        query_tag = 5'd2;
        cyc(1'b1, 1'b1, 5'd1, 1'b0);
        cyc(1'b1, 1'b1, 5'd2, 1'b0);
        cyc(1'b1, 1'b1, 5'd3, 1'b0);
        cyc(1'b0, 1'b0, 5'd0, 1'b0);
        check("ar_cnt3", 32'(inflight_cnt), 32'd3);
        chk_wb("ar_c3", 1'b1, 1'b1, 5'd1);
        check("ar_busy", 32'(query_busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("ar_wb_v", 32'(wb_v), 32'd0);
        check("ar_wb_fp", 32'(wb_fp), 32'd0);
        check("ar_wb_tag", 32'(wb_tag), 32'd0);
        check("ar_cnt", 32'(inflight_cnt), 32'd0);
        check("ar_busy_rst", 32'(query_busy), 32'd0);
        check("ar_ready", 32'(issue_ready), 32'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 5'd0, 1'b0);
            check($sformatf("ar_after_wb_v%0d", i), 32'(wb_v), 32'd0);
            check($sformatf("ar_after_cnt%0d", i), 32'(inflight_cnt), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
